frag_dispatch: RTL and testbench
================================

Name: frag_dispatch

Overview:
- Upstream producer for the fragment attribute interpolator (attrInterp).
- Accepts one triangle descriptor: vertex positions, z/attribute triples, flags, and an integer pixel bounding box. Walks the box in raster order.
- For each pixel, issues one interpolation request over a valid/ready handshake, with the pixel position converted to HardFloat recoded format (recFN).
- Triangle fields are held constant on the output for the whole walk.

Parameters:
- COORD_W, 12, width of unsigned integer pixel coordinates.
- EXP_W, 8, float exponent width (recFN).
- SIG_W, 24, float significand width (recFN); FW = EXP_W+SIG_W+1 = 33.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tri_valid  in  1  triangle descriptor valid
- tri_ready  out  1  dispatcher can accept a triangle
- tri_Pa, tri_Pb, tri_Pc  in  2*FW each  vertex positions, {x,y}, x in upper half
- tri_zabc, tri_fabc  in  3*FW each  {a,b,c} depth / attribute values, a in MSBs
- tri_flags  in  4  {isDepth,noPerspective,flat,provokeMode}
- tri_xmin, tri_xmax, tri_ymin, tri_ymax  in  COORD_W each  inclusive bounding box
- out_valid  out  1  request valid (drives attrInterp inValid)
- out_ready  in  1  attrInterp inReady
- out_P, out_Pa, out_Pb, out_Pc  out  2*FW each  sample point and vertices, {x,y}
- out_za, out_zb, out_zc, out_fa, out_fb, out_fc  out  FW each
- out_flags  out  4
- out_x, out_y  out  COORD_W each  integer pixel coordinate (sideband)
- out_last  out  1  final fragment of the triangle
- tri_done  out  1  one-cycle pulse when a triangle finishes or is discarded
- frag_count  out  2*COORD_W  fragments issued for the current or last triangle

Behaviour:
- **States:**
  - IDLE: tri_ready=1, out_valid=0.
  - SCAN: tri_ready=0, out_valid=1.
- **Reset:** state=IDLE, out_valid=0, out_last=0, tri_done=0, frag_count=0, x=y=0, all latched triangle registers=0.
- **IDLE, tri_valid=1:** latch all tri_* fields and set x=xmin, y=ymin, frag_count=0.
  - Valid box: go to SCAN next cycle.
  - Degenerate box (xmax<xmin or ymax<ymin): stay in IDLE, pulse tri_done next cycle, issue no fragments.
- **SCAN output contents:**
  - out_P = {iNToRecFN(x), iNToRecFN(y)}, unsigned, exact.
  - Pixel corner sampling: no +0.5 offset.
  - All other out_* come from the latched registers and are stable while out_valid=1.
- **Handshake:** transfer occurs on a rising edge with out_valid && out_ready. out_valid is never deasserted without a transfer.
- **Advance on each transfer:**
  - frag_count += 1.
  - If x != xmax: x++.
  - Else x=xmin; if y != ymax: y++.
  - Else (x==xmax && y==ymax): go to IDLE and pulse tri_done for one cycle.
- **out_last:** = (x==xmax && y==ymax) while in SCAN; 0 otherwise.
- **Counter width:** x/y compare on equality only, so there is no wrap. xmax = 2^COORD_W-1 is legal.
- **No overlap:** a new triangle is accepted no earlier than the cycle after the final transfer (one bubble).
- **Throughput:** one fragment per cycle when out_ready is held high. Request latency is 1 cycle from tri handshake to first out_valid.
- **Reset mid-SCAN:** abandon the triangle, return to IDLE, no tri_done pulse.
- **Ignored inputs:** tri_valid during SCAN is ignored; the descriptor must be held by the producer.

Test Plan:
- **2x2 box, out_ready held 1:** tri_xmin=1, xmax=2, ymin=0, ymax=1.
  - Four consecutive transfers (x,y) = (1,0),(2,0),(1,1),(2,1).
  - out_P of first = {33'h080000000,33'h000000000}; of fourth = {33'h080800000,33'h080000000}.
  - out_last only on 4th, tri_done 1 cycle later, frag_count=4.
- **Triangle fields pass-through:** Pa={0,0}, Pb={1.0,0}, Pc={0,1.0}, zabc all 1.0, fabc all 0.5 (33'h07F800000), flags=4'b0000, single pixel (3,3).
  - One fragment with out_P={33'h080C00000,33'h080C00000}.
  - out_Pa/out_Pb/out_Pc, z/f and flags equal the recoded inputs.
  - out_last=1.
- **Backpressure:** 1x3 box, out_ready toggling 1,0,0,1,0,1.
  - Exactly three transfers.
  - out_P held constant during out_ready=0 cycles.
  - No duplicates or skips.
- **Degenerate box:** xmin=5, xmax=4.
  - out_valid never asserts.
  - tri_done pulses once.
  - tri_ready returns high the next cycle; frag_count=0.
- **Reset mid-walk:** assert reset after 2 of 6 fragments.
  - Next cycle out_valid=0, tri_ready=1, frag_count=0, no tri_done.
  - A following 1x1 triangle dispatches normally.
- **Back-to-back triangles:** tri_valid held with a second descriptor.
  - Second is accepted exactly one cycle after the first's tri_done cycle.
  - Fragment streams do not interleave.

Source files
------------

// File: rtl/frag_dispatch.sv
// Triangle fragment dispatcher: walks an integer bounding box in raster order and issues
// one attribute-interpolation request per pixel, with the pixel position in recFN format.
module frag_dispatch #(
    parameter int unsigned COORD_W = 12,
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned SIG_W   = 24,
    localparam int unsigned FW     = EXP_W + SIG_W + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tri_valid,
    output logic                 tri_ready,
    input  logic [2*FW-1:0]      tri_Pa,
    input  logic [2*FW-1:0]      tri_Pb,
    input  logic [2*FW-1:0]      tri_Pc,
    input  logic [3*FW-1:0]      tri_zabc,
    input  logic [3*FW-1:0]      tri_fabc,
    input  logic [3:0]           tri_flags,
    input  logic [COORD_W-1:0]   tri_xmin,
    input  logic [COORD_W-1:0]   tri_xmax,
    input  logic [COORD_W-1:0]   tri_ymin,
    input  logic [COORD_W-1:0]   tri_ymax,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*FW-1:0]      out_P,
    output logic [2*FW-1:0]      out_Pa,
    output logic [2*FW-1:0]      out_Pb,
    output logic [2*FW-1:0]      out_Pc,
    output logic [FW-1:0]        out_za,
    output logic [FW-1:0]        out_zb,
    output logic [FW-1:0]        out_zc,
    output logic [FW-1:0]        out_fa,
    output logic [FW-1:0]        out_fb,
    output logic [FW-1:0]        out_fc,
    output logic [3:0]           out_flags,
    output logic [COORD_W-1:0]   out_x,
    output logic [COORD_W-1:0]   out_y,
    output logic                 out_last,
    output logic                 tri_done,
    output logic [2*COORD_W-1:0] frag_count
);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e               state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0]   xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [2*FW-1:0]      pa_q, pa_d, pb_q, pb_d, pc_q, pc_d;
    logic [3*FW-1:0]      zabc_q, zabc_d, fabc_q, fabc_d;
    logic [3:0]           flags_q, flags_d;
    logic [2*COORD_W-1:0] frag_count_q, frag_count_d;
    logic                 tri_done_q, tri_done_d;

    // Exact unsigned integer to recoded float; assumes COORD_W <= SIG_W.
    function automatic logic [FW-1:0] int_to_rec(input logic [COORD_W-1:0] v);
        logic [EXP_W:0]   exp_f;
        logic [SIG_W-1:0] norm;
        int               msb;
        msb = 0;
        for (int i = 0; i < int'(COORD_W); i++) begin
            if (v[i]) msb = i;
        end
        norm  = SIG_W'(v) << (int'(SIG_W) - 1 - msb);
        exp_f = (EXP_W + 1)'((2 ** EXP_W) + msb);
        if (v == '0) int_to_rec = '0;
        else         int_to_rec = {1'b0, exp_f, norm[SIG_W-2:0]};
    endfunction

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        xmin_d       = xmin_q;
        xmax_d       = xmax_q;
        ymin_d       = ymin_q;
        ymax_d       = ymax_q;
        pa_d         = pa_q;
        pb_d         = pb_q;
        pc_d         = pc_q;
        zabc_d       = zabc_q;
        fabc_d       = fabc_q;
        flags_d      = flags_q;
        frag_count_d = frag_count_q;
        tri_done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tri_valid) begin
                    xmin_d       = tri_xmin;
                    xmax_d       = tri_xmax;
                    ymin_d       = tri_ymin;
                    ymax_d       = tri_ymax;
                    pa_d         = tri_Pa;
                    pb_d         = tri_Pb;
                    pc_d         = tri_Pc;
                    zabc_d       = tri_zabc;
                    fabc_d       = tri_fabc;
                    flags_d      = tri_flags;
                    x_d          = tri_xmin;
                    y_d          = tri_ymin;
                    frag_count_d = '0;
                    // An empty box is retired immediately without visiting SCAN.
                    if (tri_xmax < tri_xmin || tri_ymax < tri_ymin) tri_done_d = 1'b1;
                    else                                            state_d    = StScan;
                end
            end
            StScan: begin
                if (out_ready) begin
                    frag_count_d = frag_count_q + 1'b1;
                    if (x_q != xmax_q) begin
                        x_d = x_q + 1'b1;
                    end else begin
                        x_d = xmin_q;
                        if (y_q != ymax_q) begin
                            y_d = y_q + 1'b1;
                        end else begin
                            state_d    = StIdle;
                            tri_done_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            x_q          <= '0;
            y_q          <= '0;
            xmin_q       <= '0;
            xmax_q       <= '0;
            ymin_q       <= '0;
            ymax_q       <= '0;
            pa_q         <= '0;
            pb_q         <= '0;
            pc_q         <= '0;
            zabc_q       <= '0;
            fabc_q       <= '0;
            flags_q      <= '0;
            frag_count_q <= '0;
            tri_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            xmin_q       <= xmin_d;
            xmax_q       <= xmax_d;
            ymin_q       <= ymin_d;
            ymax_q       <= ymax_d;
            pa_q         <= pa_d;
            pb_q         <= pb_d;
            pc_q         <= pc_d;
            zabc_q       <= zabc_d;
            fabc_q       <= fabc_d;
            flags_q      <= flags_d;
            frag_count_q <= frag_count_d;
            tri_done_q   <= tri_done_d;
        end
    end

    always_comb begin
        tri_ready  = (state_q == StIdle);
        out_valid  = (state_q == StScan);
        out_last   = (state_q == StScan) && (x_q == xmax_q) && (y_q == ymax_q);
        out_P      = {int_to_rec(x_q), int_to_rec(y_q)};
        out_Pa     = pa_q;
        out_Pb     = pb_q;
        out_Pc     = pc_q;
        out_za     = zabc_q[3*FW-1:2*FW];
        out_zb     = zabc_q[2*FW-1:FW];
        out_zc     = zabc_q[FW-1:0];
        out_fa     = fabc_q[3*FW-1:2*FW];
        out_fb     = fabc_q[2*FW-1:FW];
        out_fc     = fabc_q[FW-1:0];
        out_flags  = flags_q;
        out_x      = x_q;
        out_y      = y_q;
        tri_done   = tri_done_q;
        frag_count = frag_count_q;
    end

endmodule

// File: tb/tb_frag_dispatch.sv
// Directed bench for frag_dispatch: raster walk, pass-through, backpressure, degenerate box,
// mid-walk reset and back-to-back triangles.
module tb_frag_dispatch;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned FW = 33;
    localparam logic [FW-1:0] R0   = 33'h000000000;
    localparam logic [FW-1:0] R1   = 33'h080000000;
    localparam logic [FW-1:0] R2   = 33'h080800000;
    localparam logic [FW-1:0] R3   = 33'h080C00000;
    localparam logic [FW-1:0] R7   = 33'h081600000;
    localparam logic [FW-1:0] R9   = 33'h081900000;
    localparam logic [FW-1:0] R4095 = 33'h085FFF000;
    localparam logic [FW-1:0] RHALF = 33'h07F800000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tri_valid = 1'b0;
    logic tri_ready;
    logic [2*FW-1:0] tri_Pa = '0, tri_Pb = '0, tri_Pc = '0;
    logic [3*FW-1:0] tri_zabc = '0, tri_fabc = '0;
    logic [3:0] tri_flags = '0;
    logic [COORD_W-1:0] tri_xmin = '0, tri_xmax = '0, tri_ymin = '0, tri_ymax = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [2*FW-1:0] out_P, out_Pa, out_Pb, out_Pc;
    logic [FW-1:0] out_za, out_zb, out_zc, out_fa, out_fb, out_fc;
    logic [3:0] out_flags;
    logic [COORD_W-1:0] out_x, out_y;
    logic out_last, tri_done;
    logic [2*COORD_W-1:0] frag_count;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    frag_dispatch dut (
        .clk(clk), .reset(reset), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_Pa(tri_Pa), .tri_Pb(tri_Pb), .tri_Pc(tri_Pc),
        .tri_zabc(tri_zabc), .tri_fabc(tri_fabc), .tri_flags(tri_flags),
        .tri_xmin(tri_xmin), .tri_xmax(tri_xmax), .tri_ymin(tri_ymin), .tri_ymax(tri_ymax),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_P(out_P), .out_Pa(out_Pa), .out_Pb(out_Pb), .out_Pc(out_Pc),
        .out_za(out_za), .out_zb(out_zb), .out_zc(out_zc),
        .out_fa(out_fa), .out_fb(out_fb), .out_fc(out_fc),
        .out_flags(out_flags), .out_x(out_x), .out_y(out_y), .out_last(out_last),
        .tri_done(tri_done), .frag_count(frag_count)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_box(input int xmin, input int xmax, input int ymin, input int ymax);
        tri_xmin = COORD_W'(xmin);
        tri_xmax = COORD_W'(xmax);
        tri_ymin = COORD_W'(ymin);
        tri_ymax = COORD_W'(ymax);
    endtask

    logic [FW-1:0] xrec [3];
    int exp_x;
    int xfers;
    logic [0:5] rdy_pat;

    initial begin
        xrec[0] = R0; xrec[1] = R1; xrec[2] = R2;
        rdy_pat = 6'b100101;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("rst_tri_ready", 128'(tri_ready), 128'(1'b1));
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_out_last", 128'(out_last), 128'(1'b0));
        check("rst_tri_done", 128'(tri_done), 128'(1'b0));
        check("rst_frag_count", 128'(frag_count), 128'(0));
        check("rst_out_P", 128'(out_P), 128'(0));
        check("rst_out_Pa", 128'(out_Pa), 128'(0));

        // 2x2 box, out_ready held high
        set_box(1, 2, 0, 1);
        out_ready = 1'b1;
        tri_valid = 1'b1;
        tick();
        tri_valid = 1'b0;
        check("b2_tri_ready", 128'(tri_ready), 128'(1'b0));
        check("b2_first_P", 128'(out_P), 128'({R1, R0}));
        for (int yy = 0; yy <= 1; yy++) begin
            for (int xx = 1; xx <= 2; xx++) begin
                check("b2_valid", 128'(out_valid), 128'(1'b1));
                check("b2_x", 128'(out_x), 128'(xx));
                check("b2_y", 128'(out_y), 128'(yy));
                check("b2_last", 128'(out_last), 128'(xx == 2 && yy == 1));
                check("b2_count", 128'(frag_count), 128'((yy * 2) + xx - 1));
                if (xx == 2 && yy == 1) check("b2_fourth_P", 128'(out_P), 128'({R2, R1}));
                tick();
            end
        end
        check("b2_done", 128'(tri_done), 128'(1'b1));
        check("b2_idle_valid", 128'(out_valid), 128'(1'b0));
        check("b2_count_end", 128'(frag_count), 128'(4));
        tick();
        check("b2_done_pulse", 128'(tri_done), 128'(1'b0));

        // Triangle field pass-through, single pixel (3,3)
        tri_Pa = {R0, R0};
        tri_Pb = {R1, R0};
        tri_Pc = {R0, R1};
        tri_zabc = {R1, R1, R1};
        tri_fabc = {RHALF, RHALF, RHALF};
        tri_flags = 4'b0000;
        set_box(3, 3, 3, 3);
        tri_valid = 1'b1;
        tick();
        tri_valid = 1'b0;
        check("pt_valid", 128'(out_valid), 128'(1'b1));
        check("pt_P", 128'(out_P), 128'({R3, R3}));
        check("pt_Pa", 128'(out_Pa), 128'({R0, R0}));
        check("pt_Pb", 128'(out_Pb), 128'({R1, R0}));
        check("pt_Pc", 128'(out_Pc), 128'({R0, R1}));
        check("pt_z", 128'({out_za, out_zb, out_zc}), 128'({R1, R1, R1}));
        check("pt_f", 128'({out_fa, out_fb, out_fc}), 128'({RHALF, RHALF, RHALF}));
        check("pt_flags", 128'(out_flags), 128'(4'b0000));
        check("pt_last", 128'(out_last), 128'(1'b1));
        tick();
        check("pt_done", 128'(tri_done), 128'(1'b1));
        check("pt_count", 128'(frag_count), 128'(1));

        // Backpressure: 1x3 row at y=7, out_ready pattern 1,0,0,1,0,1
        set_box(0, 2, 7, 7);
        tri_flags = 4'b1010;
        tri_zabc = {R2, R1, R0};
        tri_valid = 1'b1;
        tick();
        tri_valid = 1'b0;
        check("bp_flags", 128'(out_flags), 128'(4'b1010));
        check("bp_zb", 128'(out_zb), 128'(R1));
        exp_x = 0;
        xfers = 0;
        for (int i = 0; i < 6; i++) begin
            out_ready = rdy_pat[i];
            check("bp_valid", 128'(out_valid), 128'(1'b1));
            check("bp_x", 128'(out_x), 128'(exp_x));
            check("bp_P", 128'(out_P), 128'({xrec[exp_x], R7}));
            check("bp_last", 128'(out_last), 128'(exp_x == 2));
            if (out_valid && out_ready) xfers++;
            tick();
            if (rdy_pat[i]) exp_x++;
        end
        check("bp_xfers", 128'(xfers), 128'(3));
        check("bp_done", 128'(tri_done), 128'(1'b1));
        check("bp_idle", 128'(out_valid), 128'(1'b0));
        check("bp_count", 128'(frag_count), 128'(3));
        out_ready = 1'b1;

        // Degenerate box: xmax < xmin
        set_box(5, 4, 0, 0);
        tri_valid = 1'b1;
        tick();
        tri_valid = 1'b0;
        check("dg_valid", 128'(out_valid), 128'(1'b0));
        check("dg_done", 128'(tri_done), 128'(1'b1));
        check("dg_ready", 128'(tri_ready), 128'(1'b1));
        check("dg_count", 128'(frag_count), 128'(0));
        tick();
        check("dg_valid2", 128'(out_valid), 128'(1'b0));
        check("dg_done_pulse", 128'(tri_done), 128'(1'b0));

        // Reset after 2 of 6 fragments
        set_box(0, 5, 0, 0);
        tri_valid = 1'b1;
        tick();
        tri_valid = 1'b0;
        tick();
        tick();
        check("rm_x", 128'(out_x), 128'(2));
        check("rm_count", 128'(frag_count), 128'(2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_valid", 128'(out_valid), 128'(1'b0));
        check("rm_ready", 128'(tri_ready), 128'(1'b1));
        check("rm_count0", 128'(frag_count), 128'(0));
        check("rm_done", 128'(tri_done), 128'(1'b0));
        tick();
        check("rm_done2", 128'(tri_done), 128'(1'b0));
        check("rm_valid2", 128'(out_valid), 128'(1'b0));

        // 1x1 triangle at the top corner of the coordinate range
        set_box(4095, 4095, 4095, 4095);
        tri_valid = 1'b1;
        tick();
        tri_valid = 1'b0;
        check("mx_valid", 128'(out_valid), 128'(1'b1));
        check("mx_P", 128'(out_P), 128'({R4095, R4095}));
        check("mx_last", 128'(out_last), 128'(1'b1));
        tick();
        check("mx_done", 128'(tri_done), 128'(1'b1));
        check("mx_idle", 128'(out_valid), 128'(1'b0));
        check("mx_count", 128'(frag_count), 128'(1));

        // Back-to-back: tri_valid held, second descriptor presented during the first walk
        set_box(0, 1, 2, 2);
        tri_valid = 1'b1;
        tick();
        set_box(9, 9, 1, 1);
        check("bb_x0", 128'(out_x), 128'(0));
        check("bb_P0", 128'(out_P), 128'({R0, R2}));
        tick();
        check("bb_x1", 128'(out_x), 128'(1));
        check("bb_y1", 128'(out_y), 128'(2));
        check("bb_last1", 128'(out_last), 128'(1'b1));
        tick();
        check("bb_done1", 128'(tri_done), 128'(1'b1));
        check("bb_gap", 128'(out_valid), 128'(1'b0));
        check("bb_ready", 128'(tri_ready), 128'(1'b1));
        tick();
        tri_valid = 1'b0;
        check("bb_valid2", 128'(out_valid), 128'(1'b1));
        check("bb_P2", 128'(out_P), 128'({R9, R1}));
        check("bb_count2", 128'(frag_count), 128'(0));
        check("bb_done_clr", 128'(tri_done), 128'(1'b0));
        check("bb_last2", 128'(out_last), 128'(1'b1));
        tick();
        check("bb_done2", 128'(tri_done), 128'(1'b1));
        check("bb_count_end", 128'(frag_count), 128'(1));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
